// File: rtl/vga_out_engine.sv
// VGA timing generator, pixel-coordinate issuer and TinyTapeout pin packer.
// Sync and blanking pass through a PIX_LAT-tick delay line so they stay aligned with the engine colour.
module vga_out_engine #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0,
  parameter int PIX_LAT  = 2,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    mode,
  input  logic [7:0]    pix_rgb,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_req,
  output logic          frame_start,
  output logic [7:0]    uo_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_SS     = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_SE     = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_SS     = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_SE     = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          SYNC_ON  = (SYNC_POL != 0);
  localparam logic          SYNC_OFF = (SYNC_POL == 0);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } stage_t;

  localparam stage_t STAGE_RST = '{hs: SYNC_OFF, vs: SYNC_OFF, act: 1'b0, x: '0, y: '0};

  logic [DW-1:0] div_q;
  logic [CW-1:0] h_q;
  logic [CW-1:0] v_q;
  logic          tick;
  logic          h_wrap;
  logic          v_wrap;
  logic          active;
  logic          hs_now;
  logic          vs_now;
  stage_t        stage_in;
  stage_t        dl_q [PIX_LAT];
  stage_t        tail;
  logic [1:0]    mode_q;
  logic [2:0]    bar;
  logic [7:0]    colour;
  logic [7:0]    uo_d;
  logic          unused_bits;

  assign tick        = (div_q == DIV_LAST);
  assign h_wrap      = (h_q == H_LAST);
  assign v_wrap      = (v_q == V_LAST);
  assign active      = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_now      = ((h_q >= H_SS) && (h_q < H_SE)) ? SYNC_ON : SYNC_OFF;
  assign vs_now      = ((v_q >= V_SS) && (v_q < V_SE)) ? SYNC_ON : SYNC_OFF;
  assign pix_x       = h_q;
  assign pix_y       = v_q;
  assign pix_req     = tick & active;
  assign frame_start = tick & (h_q == '0) & (v_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      if (tick) begin
        h_q <= h_wrap ? '0 : h_q + 1'b1;
        if (h_wrap) begin
          v_q <= v_wrap ? '0 : v_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    stage_in = '{hs: hs_now, vs: vs_now, act: active, x: h_q, y: v_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIX_LAT; i++) begin
        dl_q[i] <= STAGE_RST;
      end
    end else if (tick) begin
      dl_q[0] <= stage_in;
      for (int i = 1; i < PIX_LAT; i++) begin
        dl_q[i] <= dl_q[i-1];
      end
    end
  end

  // Mode only changes on the frame_start tick so a frame is never drawn in two modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'b00;
    end else if (frame_start) begin
      mode_q <= mode;
    end
  end

  always_comb begin
    tail   = dl_q[PIX_LAT-1];
    bar    = tail.x[CW-1:CW-3];
    colour = 8'h00;
    if (tail.act) begin
      unique case (mode_q)
        2'b00, 2'b01: colour = pix_rgb;
        2'b10:        colour = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
        default:      colour = ((tail.x[4:0] == 5'd0) || (tail.y[4:0] == 5'd0)) ? 8'hFF : 8'h00;
      endcase
    end
  end

  // colour is {r[2:0], g[2:0], b[1:0]}; the PMOD layout interleaves the two MSBs of each channel.
  always_comb begin
    if (mode_q == 2'b00) begin
      uo_d = {colour[7:6], colour[4:3], colour[1:0], tail.hs, tail.vs};
    end else begin
      uo_d = {tail.hs, colour[0], colour[3], colour[6], tail.vs, colour[1], colour[4], colour[7]};
    end
  end

  assign unused_bits = ^{colour[5], colour[2], tail.x, tail.y};

  always_ff @(posedge clk) begin
    if (rst) begin
      uo_out <= {6'b000000, SYNC_OFF, SYNC_OFF};
    end else if (tick) begin
      uo_out <= uo_d;
    end
  end

endmodule

// File: tb/tb_vga_out_engine.sv
// Self-checking bench for vga_out_engine using a shrunk raster so several frames fit in a short run.
// An arithmetic model derives every output from the tick count since reset and the sampled inputs.
module tb_vga_out_engine;

  localparam int CLK_DIV = 2;
  localparam int HA = 40, HFP = 4, HS = 6, HBP = 6;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int SP = 0, LAT = 2, CW = 6;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam logic SON  = (SP != 0);
  localparam logic SOFF = (SP == 0);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic [7:0]    pix_rgb = 8'h00;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_req, frame_start;
  logic [7:0]    uo_out;

  vga_out_engine #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(SP), .PIX_LAT(LAT), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .pix_rgb(pix_rgb),
    .pix_x(pix_x), .pix_y(pix_y), .pix_req(pix_req),
    .frame_start(frame_start), .uo_out(uo_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_print = 0;
  int pat_kind = 0;

  int         mdl_cyc = 0;
  logic [1:0] mdl_mode = 2'b00;
  logic [7:0] exp_uo = 8'h03;
  bit         tick_edge = 1'b0;
  bit         chk_en = 1'b0;

  function automatic logic [7:0] pack(input logic [1:0] m, input logic [7:0] c, input logic hs, input logic vs);
    if (m == 2'b00) return {c[7:6], c[4:3], c[1:0], hs, vs};
    return {hs, c[0], c[3], c[6], vs, c[1], c[4], c[7]};
  endfunction

  function automatic logic [7:0] mdl_out(input int p, input logic [1:0] m, input logic [7:0] rgb);
    int ph, pv, bar;
    logic hsl, vsl, act;
    logic [7:0] c;
    if (p < 0) return pack(m, 8'h00, SOFF, SOFF);
    ph  = p % HT;
    pv  = (p / HT) % VT;
    hsl = (ph >= HA + HFP && ph < HA + HFP + HS) ? SON : SOFF;
    vsl = (pv >= VA + VFP && pv < VA + VFP + VS) ? SON : SOFF;
    act = (ph < HA) && (pv < VA);
    c   = 8'h00;
    if (act) begin
      case (m)
        2'd0, 2'd1: c = rgb;
        2'd2: begin
          bar = ph >> (CW - 3);
          c = {((bar & 4) != 0) ? 3'b111 : 3'b000, ((bar & 2) != 0) ? 3'b111 : 3'b000,
               ((bar & 1) != 0) ? 2'b11 : 2'b00};
        end
        default: c = ((ph % 32) == 0 || (pv % 32) == 0) ? 8'hFF : 8'h00;
      endcase
    end
    return pack(m, c, hsl, vsl);
  endfunction

  function automatic logic [7:0] pat_data(input int p);
    int ph, pv;
    if (p < 0) return 8'h00;
    ph = p % HT;
    pv = (p / HT) % VT;
    case (pat_kind)
      1: return (ph == 0 && pv == 0) ? 8'hFF : 8'h00;
      2: return 8'hFF;
      3: return 8'hE0;
      default: return 8'h00;
    endcase
  endfunction

  // Model: advance on every clock edge from the bench's own cycle count.
  always @(posedge clk) begin
    int n;
    if (rst) begin
      mdl_cyc   = 0;
      mdl_mode  = 2'b00;
      exp_uo    = pack(2'b00, 8'h00, SOFF, SOFF);
      tick_edge = 1'b0;
      chk_en    = 1'b1;
    end else begin
      tick_edge = ((mdl_cyc % CLK_DIV) == CLK_DIV - 1);
      if (tick_edge) begin
        n = mdl_cyc / CLK_DIV;
        exp_uo = mdl_out(n - LAT, mdl_mode, pix_rgb);
        if ((n % FT) == 0) mdl_mode = mode;
      end
      mdl_cyc++;
    end
  end

  // Engine stand-in: supplies the data slot LAT ticks after each pixel, junk between ticks.
  always @(posedge clk) begin
    int c;
    #1;
    c = mdl_cyc;
    if ((c % CLK_DIV) == CLK_DIV - 1) pix_rgb = pat_data(c / CLK_DIV - LAT);
    else pix_rgb = 8'h5A;
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    int t, eh, ev;
    logic etk, ereq, efs;
    if (chk_en) begin
      t    = mdl_cyc / CLK_DIV;
      etk  = ((mdl_cyc % CLK_DIV) == CLK_DIV - 1);
      eh   = t % HT;
      ev   = (t / HT) % VT;
      ereq = etk && (eh < HA) && (ev < VA);
      efs  = etk && (eh == 0) && (ev == 0);
      n_tests++;
      if (pix_x !== CW'(eh) || pix_y !== CW'(ev) || pix_req !== ereq || frame_start !== efs || uo_out !== exp_uo) begin
        n_fail++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL cycle_compare t=%0t: got x=%0d y=%0d req=%0b fs=%0b uo=%02h expected x=%0d y=%0d req=%0b fs=%0b uo=%02h",
                   $time, pix_x, pix_y, pix_req, frame_start, uo_out, eh, ev, ereq, efs, exp_uo);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_to(input int h, input int v);
    int g, c;
    g = 0;
    forever begin
      c = mdl_cyc;
      if ((c % CLK_DIV) == CLK_DIV - 1 && ((c / CLK_DIV) % HT) == h && (((c / CLK_DIV) / HT) % VT) == v) break;
      if (g > 2 * FT * CLK_DIV + 4) begin
        n_tests++;
        n_fail++;
        $display("FAIL run_to(%0d,%0d): got timeout expected position reached", h, v);
        break;
      end
      @(negedge clk);
      g++;
    end
  endtask

  task automatic next_tick();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!tick_edge && g <= CLK_DIV + 1);
    n_tests++;
    if (!tick_edge) begin
      n_fail++;
      $display("FAIL next_tick: got no tick expected one within %0d clks", CLK_DIV + 1);
    end
  endtask

  task automatic frame_window(output int n_req, output int n_lit, output int n_blank,
                              output int n_hs, output int n_vs, output int lit_pos);
    n_req = 0; n_lit = 0; n_blank = 0; n_hs = 0; n_vs = 0; lit_pos = -1;
    for (int i = 0; i < FT * CLK_DIV; i++) begin
      @(negedge clk);
      if (pix_req) n_req++;
      if (tick_edge) begin
        if (uo_out[7:2] == 6'h3F) begin
          n_lit++;
          lit_pos = (mdl_cyc / CLK_DIV - 1) % FT;
        end
        if (uo_out[7:2] == 6'h00) n_blank++;
        if (!uo_out[1]) n_hs++;
        if (!uo_out[0]) n_vs++;
      end
    end
  endtask

  initial begin
    int found, n_req, n_lit, n_blank, n_hs, n_vs, lit_pos;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_uo_out", uo_out, 8'h03);
    check("reset_pix_x", pix_x, 0);
    check("reset_pix_y", pix_y, 0);
    check("reset_pix_req", pix_req, 0);
    pat_kind = 1;
    rst = 1'b0;

    found = -1;
    for (int i = 0; i < CLK_DIV + 2; i++) begin
      if (frame_start && found < 0) found = i;
      @(negedge clk);
    end
    check("first_tick_frame_start", found, CLK_DIV - 1);

    // Single lit pixel at (0,0): appears once per frame, LAT ticks after its request.
    frame_window(n_req, n_lit, n_blank, n_hs, n_vs, lit_pos);
    check("req_per_frame", n_req, HA * VA);
    check("lit_count", n_lit, 1);
    check("lit_position", lit_pos, LAT);
    check("hs_low_ticks", n_hs, HS * VT);
    check("vs_low_ticks", n_vs, VS * HT);

    pat_kind = 2;
    run_to(0, 0);
    frame_window(n_req, n_lit, n_blank, n_hs, n_vs, lit_pos);
    check("full_white_lit", n_lit, HA * VA);
    check("full_white_blank", n_blank, FT - HA * VA);

    // Mode change mid-frame holds off until the next frame.
    pat_kind = 3;
    run_to(5, 3);
    mode = 2'b01;
    @(negedge clk);
    check("legacy_after_switch", uo_out, 8'hC3);
    run_to(20, 5);
    @(negedge clk);
    check("legacy_end_of_frame", uo_out, 8'hC3);
    run_to(0, 0);
    run_to(10, 1);
    @(negedge clk);
    check("pmod_e0_active", uo_out, 8'h99);
    run_to(48, 1);
    @(negedge clk);
    check("pmod_hsync", uo_out, 8'h08);

    mode = 2'b10;
    run_to(0, 0);
    run_to(7, 2);
    @(negedge clk);
    check("bar0", uo_out, 8'h88);
    run_to(12, 2);
    @(negedge clk);
    check("bar1", uo_out, 8'hCC);
    run_to(36, 2);
    @(negedge clk);
    check("bar4", uo_out, 8'h99);

    mode = 2'b11;
    run_to(0, 0);
    run_to(2, 1);
    @(negedge clk);
    check("grid_x0", uo_out, 8'hFF);
    run_to(4, 1);
    @(negedge clk);
    check("grid_off", uo_out, 8'h88);
    run_to(34, 1);
    @(negedge clk);
    check("grid_x32", uo_out, 8'hFF);

    // Reset mid-frame; mode input stays 10 so the first post-reset tick shows the mode register was cleared.
    mode = 2'b10;
    run_to(0, 0);
    run_to(30, 3);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_uo_out", uo_out, 8'h03);
    check("midreset_pix_x", pix_x, 0);
    check("midreset_pix_y", pix_y, 0);
    check("midreset_pix_req", pix_req, 0);
    rst = 1'b0;
    next_tick();
    check("post_reset_legacy", uo_out, 8'h03);
    next_tick();
    check("post_reset_mode_captured", uo_out, 8'h88);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
